trivia_countdown: RTL and testbench

TRIVIA_COUNTDOWN -- requirements
Module: trivia_countdown

---
 rtl/trivia_countdown_if.sv | 11 +
 rtl/trivia_countdown.sv | 151 +++++++++++++++
 tb/tb_trivia_countdown.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/trivia_countdown_if.sv
// Avalon-MM slave bus bundle for the trivia countdown timer.
interface trivia_countdown_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/trivia_countdown.sv
// Quiz-round countdown: ticks from an interval timer are prescaled into seconds,
// counted down from LOAD_SEC, shown as BCD and reported as an expiry interrupt.
module trivia_countdown #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned LOAD_RESET    = 30
) (
    input  logic                clk,
    input  logic                reset_n,
    trivia_countdown_if.slave   bus,
    input  logic                tick,
    output logic                irq,
    output logic [11:0]         seconds_bcd,
    output logic                running
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [15:0] PRESC_LAST = 16'(TICKS_PER_SEC - 1);
    localparam logic [9:0]  LOAD_INIT  = 10'(LOAD_RESET);

    state_t      state_r, state_next_s;
    logic [9:0]  load_sec_r, remaining_r, remaining_next_s;
    logic [15:0] prescaler_r, prescaler_next_s;
    logic        expired_r, expired_next_s;
    logic        tick_d_r, irq_en_r, running_r;
    logic [15:0] readdata_r, rd_mux_s;
    logic [11:0] bcd_r;
    logic        wr_s, status_wr_s, start_s, stop_s, edge_s;

    // Shift-and-add-3 conversion of a 10-bit count into three BCD digits.
    function automatic logic [11:0] bin_to_bcd(input logic [9:0] bin);
        logic [21:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 10; i++) begin
            sh[13:10] = (sh[13:10] > 4'd4) ? sh[13:10] + 4'd3 : sh[13:10];
            sh[17:14] = (sh[17:14] > 4'd4) ? sh[17:14] + 4'd3 : sh[17:14];
            sh[21:18] = (sh[21:18] > 4'd4) ? sh[21:18] + 4'd3 : sh[21:18];
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

    assign wr_s        = bus.chipselect && !bus.write_n;
    assign status_wr_s = wr_s && (bus.address == 3'd0);
    assign start_s     = wr_s && (bus.address == 3'd1) && bus.writedata[1];
    assign stop_s      = wr_s && (bus.address == 3'd1) && bus.writedata[2];
    assign edge_s      = tick && !tick_d_r;

    assign irq          = expired_r && irq_en_r;
    assign running      = running_r;
    assign seconds_bcd  = bcd_r;
    assign bus.readdata = readdata_r;

    // Register read multiplexer; unmapped words read as zero.
    always_comb begin
        rd_mux_s = 16'd0;
        case (bus.address)
            3'd0:    rd_mux_s = {14'd0, running_r, expired_r};
            3'd1:    rd_mux_s = {15'd0, irq_en_r};
            3'd2:    rd_mux_s = {6'd0, load_sec_r};
            3'd3:    rd_mux_s = {6'd0, remaining_r};
            3'd4:    rd_mux_s = {4'd0, bcd_r};
            default: rd_mux_s = 16'd0;
        endcase
    end

    // Countdown FSM next-state; an expiry event overrides a same-cycle STATUS clear.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        prescaler_next_s = prescaler_r;
        if (status_wr_s) begin
            expired_next_s = 1'b0;
        end else begin
            expired_next_s = expired_r;
        end

        if (stop_s) begin
            state_next_s = IDLE;
        end else if (start_s) begin
            remaining_next_s = load_sec_r;
            prescaler_next_s = 16'd0;
            if (load_sec_r == 10'd0) begin
                state_next_s   = DONE;
                expired_next_s = 1'b1;
            end else begin
                state_next_s = RUN;
            end
        end else begin
            case (state_r)
                RUN: begin
                    if (edge_s) begin
                        if (prescaler_r == PRESC_LAST) begin
                            prescaler_next_s = 16'd0;
                            remaining_next_s = remaining_r - 10'd1;
                            if (remaining_r == 10'd1) begin
                                state_next_s   = DONE;
                                expired_next_s = 1'b1;
                            end else begin
                                state_next_s = RUN;
                            end
                        end else begin
                            prescaler_next_s = prescaler_r + 16'd1;
                        end
                    end else begin
                        prescaler_next_s = prescaler_r;
                    end
                end
                IDLE:    state_next_s = IDLE;
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, counters, configuration registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            load_sec_r  <= LOAD_INIT;
            remaining_r <= 10'd0;
            prescaler_r <= 16'd0;
            expired_r   <= 1'b0;
            tick_d_r    <= 1'b0;
            irq_en_r    <= 1'b0;
            running_r   <= 1'b0;
            readdata_r  <= 16'd0;
            bcd_r       <= 12'd0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            prescaler_r <= prescaler_next_s;
            expired_r   <= expired_next_s;
            tick_d_r    <= tick;
            running_r   <= (state_next_s == RUN);
            readdata_r  <= rd_mux_s;
            bcd_r       <= bin_to_bcd(remaining_r);
            if (wr_s && (bus.address == 3'd1)) begin
                irq_en_r <= bus.writedata[0];
            end else begin
                irq_en_r <= irq_en_r;
            end
            if (wr_s && (bus.address == 3'd2)) begin
                load_sec_r <= (bus.writedata > 16'd999) ? 10'd999 : bus.writedata[9:0];
            end else begin
                load_sec_r <= load_sec_r;
            end
        end
    end

endmodule

// File: tb/tb_trivia_countdown.sv
// Self-checking bench for trivia_countdown: register table plus countdown scenarios.
module tb_trivia_countdown;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic        irq;
    logic [11:0] seconds_bcd;
    logic        running;

    trivia_countdown_if bus();

    trivia_countdown #(.TICKS_PER_SEC(4), .LOAD_RESET(30)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .tick(tick),
        .irq(irq), .seconds_bcd(seconds_bcd), .running(running)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { string name; logic [15:0] exp; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // One clock; results of reads issued in the previous cycle are checked here.
    task automatic cyc();
        sb_t e;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.name, bus.readdata, e.exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] data);
        bus.address = addr; bus.writedata = data; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cyc();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] addr, input string name, input logic [15:0] exp);
        sb_t e;
        bus.address = addr;
        e.name = name; e.exp = exp;
        sb_q.push_back(e);
        cyc();
    endtask

    task automatic tick_edge();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bcd_vals[5] = '{407, 90, 10, 1, 500};

        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 16'd0;
        vecs[0]  = '{"rd_load_rst",    1'b1, 1'b1, 3'd2, 16'd0,      1'b1, 16'd30};
        vecs[1]  = '{"rd_status_rst",  1'b1, 1'b1, 3'd0, 16'd0,      1'b1, 16'd0};
        vecs[2]  = '{"rd_rem_rst",     1'b1, 1'b1, 3'd3, 16'd0,      1'b1, 16'd0};
        vecs[3]  = '{"rd_bcd_rst",     1'b1, 1'b1, 3'd4, 16'd0,      1'b1, 16'd0};
        vecs[4]  = '{"rd_addr5",       1'b1, 1'b1, 3'd5, 16'd0,      1'b1, 16'd0};
        vecs[5]  = '{"wr_load_1234",   1'b1, 1'b0, 3'd2, 16'd1234,   1'b0, 16'd0};
        vecs[6]  = '{"rd_load_sat",    1'b1, 1'b1, 3'd2, 16'd0,      1'b1, 16'd999};
        vecs[7]  = '{"wr_load_1000",   1'b1, 1'b0, 3'd2, 16'd1000,   1'b0, 16'd0};
        vecs[8]  = '{"rd_load_sat2",   1'b1, 1'b1, 3'd2, 16'd0,      1'b1, 16'd999};
        vecs[9]  = '{"wr_load_7",      1'b1, 1'b0, 3'd2, 16'd7,      1'b0, 16'd0};
        vecs[10] = '{"rd_load_nocs",   1'b0, 1'b1, 3'd2, 16'd0,      1'b1, 16'd7};
        vecs[11] = '{"wr_load_nocs",   1'b0, 1'b0, 3'd2, 16'd5,      1'b0, 16'd0};
        vecs[12] = '{"rd_load_kept",   1'b1, 1'b1, 3'd2, 16'd0,      1'b1, 16'd7};
        vecs[13] = '{"wr_addr5",       1'b1, 1'b0, 3'd5, 16'hFFFF,   1'b0, 16'd0};
        vecs[14] = '{"rd_addr5_after", 1'b1, 1'b1, 3'd5, 16'd0,      1'b1, 16'd0};
        vecs[15] = '{"rd_addr7",       1'b1, 1'b1, 3'd7, 16'd0,      1'b1, 16'd0};
        vecs[16] = '{"wr_load_999",    1'b1, 1'b0, 3'd2, 16'd999,    1'b0, 16'd0};
        vecs[17] = '{"rd_load_999",    1'b1, 1'b1, 3'd2, 16'd0,      1'b1, 16'd999};

        cyc(); cyc();
        check("rst_irq", 16'(irq), 16'd0);
        check("rst_running", 16'(running), 16'd0);
        check("rst_bcd", 16'(seconds_bcd), 16'd0);
        check("rst_readdata", bus.readdata, 16'd0);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 18; i++) begin
            bus.chipselect = vecs[i].cs; bus.write_n = vecs[i].wn;
            bus.address = vecs[i].addr; bus.writedata = vecs[i].wdata;
            if (vecs[i].chk) begin
                sb_q.push_back('{vecs[i].name, vecs[i].exp});
            end
            cyc();
            bus.chipselect = 1'b0; bus.write_n = 1'b1;
        end

        // Two-second countdown at four ticks per second.
        wr(3'd2, 16'd2); wr(3'd1, 16'd1);
        check("irq_before_start", 16'(irq), 16'd0);
        wr(3'd1, 16'd3);
        check("run_after_start", 16'(running), 16'd1);
        rd(3'd3, "rem_start", 16'd2);
        for (int e = 1; e <= 8; e++) begin
            tick = 1'b1; cyc();
            if (e == 7) begin
                check("irq_edge7", 16'(irq), 16'd0);
                check("running_edge7", 16'(running), 16'd1);
            end
            if (e == 8) begin
                check("irq_edge8", 16'(irq), 16'd1);
                check("running_edge8", 16'(running), 16'd0);
            end
            tick = 1'b0; cyc();
            if (e == 4) rd(3'd3, "rem_after4", 16'd1);
        end
        rd(3'd0, "status_done", 16'd1);
        rd(3'd3, "rem_done", 16'd0);
        check("bcd_done", 16'(seconds_bcd), 16'd0);
        tick_edge(); tick_edge();
        rd(3'd0, "status_done_ticks", 16'd1);
        wr(3'd1, 16'd0);
        check("irq_en_off", 16'(irq), 16'd0);
        rd(3'd0, "expired_kept", 16'd1);
        wr(3'd1, 16'd1);
        check("irq_en_on", 16'(irq), 16'd1);
        wr(3'd0, 16'd0);
        check("irq_cleared", 16'(irq), 16'd0);
        rd(3'd0, "status_cleared", 16'd0);

        // STATUS clear coinciding with the final decrement.
        wr(3'd2, 16'd1); wr(3'd1, 16'd3);
        tick_edge(); tick_edge(); tick_edge();
        tick = 1'b1;
        bus.address = 3'd0; bus.writedata = 16'hFFFF; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        cyc();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; tick = 1'b0;
        check("irq_expiry_wins", 16'(irq), 16'd1);
        rd(3'd0, "status_expiry_wins", 16'd1);
        wr(3'd0, 16'd0);
        check("irq_after_clear", 16'(irq), 16'd0);
        rd(3'd0, "status_after_clear", 16'd0);

        // Zero load expires immediately.
        wr(3'd2, 16'd0); wr(3'd1, 16'd2);
        check("running_load0", 16'(running), 16'd0);
        check("irq_load0_disabled", 16'(irq), 16'd0);
        rd(3'd0, "status_load0", 16'd1);
        rd(3'd3, "rem_load0", 16'd0);
        wr(3'd0, 16'd0);

        // Stop holds the count; start+stop while idle does nothing.
        wr(3'd2, 16'd3); wr(3'd1, 16'd2);
        tick_edge();
        wr(3'd1, 16'd4);
        check("running_after_stop", 16'(running), 16'd0);
        rd(3'd3, "rem_stop_hold", 16'd3);
        wr(3'd2, 16'd5); wr(3'd1, 16'd6);
        check("running_startstop", 16'(running), 16'd0);
        rd(3'd3, "rem_startstop", 16'd3);
        tick_edge(); tick_edge(); tick_edge();
        rd(3'd3, "rem_idle_ticks", 16'd3);
        rd(3'd0, "status_idle_ticks", 16'd0);

        // Saturated load, BCD latency and LOAD_SEC writes during RUN.
        wr(3'd2, 16'd1234);
        rd(3'd2, "load_1234", 16'd999);
        wr(3'd1, 16'd2);
        check("bcd_lag", 16'(seconds_bcd), 16'h0003);
        cyc();
        check("bcd_999", 16'(seconds_bcd), 16'h0999);
        rd(3'd4, "rd_bcd_999", 16'h0999);
        wr(3'd2, 16'd5);
        rd(3'd3, "rem_unaffected", 16'd999);
        for (int k = 0; k < 5; k++) begin
            wr(3'd2, 16'(bcd_vals[k])); wr(3'd1, 16'd2); cyc();
            check($sformatf("bcd_%0d", bcd_vals[k]), 16'(seconds_bcd), 16'(to_bcd(bcd_vals[k])));
        end

        // Asynchronous reset in the middle of a countdown.
        wr(3'd2, 16'd5); wr(3'd1, 16'd3);
        rd(3'd3, "rem_before_rst", 16'd5);
        #2 reset_n = 1'b0;
        #1;
        check("arst_running", 16'(running), 16'd0);
        check("arst_irq", 16'(irq), 16'd0);
        check("arst_bcd", 16'(seconds_bcd), 16'd0);
        check("arst_readdata", bus.readdata, 16'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        rd(3'd2, "load_after_rst", 16'd30);
        for (int t = 0; t < 8; t++) tick_edge();
        rd(3'd3, "rem_after_rst", 16'd0);
        rd(3'd0, "status_after_rst", 16'd0);
        check("running_after_rst", 16'(running), 16'd0);
        check("irq_after_rst", 16'(irq), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
